// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: source count, APB register
// map and the position of the valid flag inside the ID register.
package irq_ctrl_pkg;

   localparam int NUM_SRC      = 8;
   localparam int ID_W         = 3;
   localparam int ID_VALID_BIT = 31;

   localparam logic [11:0] OFF_IER = 12'h000;
   localparam logic [11:0] OFF_IPR = 12'h004;
   localparam logic [11:0] OFF_ITR = 12'h008;
   localparam logic [11:0] OFF_ID  = 12'h00C;
   localparam logic [11:0] OFF_ACK = 12'h010;

   typedef enum logic [2:0] {
      REG_IER,
      REG_IPR,
      REG_ITR,
      REG_ID,
      REG_ACK,
      REG_NONE
   } reg_sel_e;

   // Maps a 12-bit byte offset onto the register it selects.
   function automatic reg_sel_e decode_offset(input logic [11:0] off);
      reg_sel_e sel;
      case (off)
         OFF_IER: sel = REG_IER;
         OFF_IPR: sel = REG_IPR;
         OFF_ITR: sel = REG_ITR;
         OFF_ID:  sel = REG_ID;
         OFF_ACK: sel = REG_ACK;
         default: sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of the active vector wins.
module irq_prio_enc
   import irq_ctrl_pkg::*;
(
   input  logic [7:0]      active,
   output logic [ID_W-1:0] id,
   output logic            valid
);

   // Scan from the top so the lowest set index is the last one to write id.
   always_comb begin
      id    = '0;
      valid = |active;
      for (int i = 7; i >= 0; i--) begin
         if (active[i]) begin
            id = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// APB-programmable interrupt controller with per-source enable, pending and
// trigger-mode registers, fixed priority and a registered combined irq.
module irq_ctrl #(
   parameter int NUM_SRC = irq_ctrl_pkg::NUM_SRC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               psel,
   input  logic               penable,
   input  logic               pwrite,
   input  logic [31:0]        paddr,
   input  logic [31:0]        pwdata,
   output logic [31:0]        prdata,
   output logic               pready,
   output logic               pslverr,
   input  logic [NUM_SRC-1:0] intr_src,
   output logic               irq,
   output logic [2:0]         irq_id
);

   import irq_ctrl_pkg::*;

   if (NUM_SRC != 8) begin : g_bad_num_src
      $error("irq_ctrl only supports NUM_SRC = 8");
   end

   logic               access;
   logic               bad_access;
   logic               wr_en;
   logic               rd_en;
   reg_sel_e           sel;

   logic [NUM_SRC-1:0] ier_q, ier_d;
   logic [NUM_SRC-1:0] ipr_q, ipr_d;
   logic [NUM_SRC-1:0] itr_q, itr_d;
   logic [NUM_SRC-1:0] src_q, src_d;
   logic               irq_q, irq_d;

   logic [NUM_SRC-1:0] set_vec;
   logic [NUM_SRC-1:0] clr_vec;
   logic [NUM_SRC-1:0] active;
   logic               id_valid;

   logic               unused_bits;
   assign unused_bits = ^{paddr[31:12], pwdata[31:NUM_SRC]};

   // Decode the APB access and classify it as a clean read, clean write or error.
   always_comb begin
      access     = psel & penable;
      sel        = decode_offset(paddr[11:0]);
      bad_access = (paddr[1:0] != 2'b00) | (sel == REG_NONE) |
                   (pwrite & (sel == REG_ID)) | (~pwrite & (sel == REG_ACK));
      wr_en      = access & pwrite & ~bad_access;
      rd_en      = access & ~pwrite & ~bad_access;
   end

   assign pready  = access;
   assign pslverr = access & bad_access;

   assign active = ipr_q & ier_q;

   irq_prio_enc u_prio_enc (
      .active (active),
      .id     (irq_id),
      .valid  (id_valid)
   );

   // Next register state: APB writes, pending set/clear with set winning, edge history.
   always_comb begin
      ier_d   = ier_q;
      itr_d   = itr_q;
      clr_vec = '0;
      if (wr_en) begin
         case (sel)
            REG_IER: ier_d   = pwdata[NUM_SRC-1:0];
            REG_ITR: itr_d   = pwdata[NUM_SRC-1:0];
            REG_IPR: clr_vec = pwdata[NUM_SRC-1:0];
            REG_ACK: clr_vec = NUM_SRC'(1) << pwdata[2:0];
            default: clr_vec = '0;
         endcase
      end
      set_vec = (itr_q & intr_src & ~src_q) | (~itr_q & intr_src);
      ipr_d   = (ipr_q & ~clr_vec) | set_vec;
      src_d   = intr_src;
      irq_d   = |active;
   end

   // Read mux; anything other than a clean read returns zero.
   always_comb begin
      prdata = '0;
      if (rd_en) begin
         case (sel)
            REG_IER: prdata = 32'(ier_q);
            REG_IPR: prdata = 32'(ipr_q);
            REG_ITR: prdata = 32'(itr_q);
            REG_ID: begin
               prdata[ID_VALID_BIT] = id_valid;
               prdata[ID_W-1:0]     = irq_id;
            end
            default: prdata = '0;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ier_q <= '0;
         ipr_q <= '0;
         itr_q <= '0;
         src_q <= '0;
         irq_q <= 1'b0;
      end else begin
         ier_q <= ier_d;
         ipr_q <= ipr_d;
         itr_q <= itr_d;
         src_q <= src_d;
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random APB and
// interrupt traffic, checked by a monitor against a behavioural model.
module tb_irq_ctrl;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b1;
   logic        psel     = 1'b0;
   logic        penable  = 1'b0;
   logic        pwrite   = 1'b0;
   logic [31:0] paddr    = '0;
   logic [31:0] pwdata   = '0;
   logic [7:0]  intr_src = '0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        irq;
   logic [2:0]  irq_id;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } respT;

   respT        expQ[$];
   respT        monExp;
   int          errCount   = 0;
   int          checkCount = 0;
   bit          randSrc    = 1'b0;

   logic [7:0]  mIer      = '0;
   logic [7:0]  mIpr      = '0;
   logic [7:0]  mItr      = '0;
   logic [7:0]  mSrcPrev  = '0;
   logic        mIrq      = 1'b0;

   always #5 clk = ~clk;

   irq_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr),
      .intr_src (intr_src),
      .irq      (irq),
      .irq_id   (irq_id)
   );

   // Register map rules: which accesses are refused.
   function automatic bit addrError(input logic [31:0] addr, input bit wr);
      logic [11:0] off;
      bit          mapped;
      off    = addr[11:0];
      mapped = (off == 12'h000) || (off == 12'h004) || (off == 12'h008) ||
               (off == 12'h00C) || (off == 12'h010);
      return !mapped || (wr && off == 12'h00C) || (!wr && off == 12'h010);
   endfunction

   // Index of the lowest set bit, 0 if none.
   function automatic logic [2:0] modelId(input logic [7:0] act);
      int k;
      k = 0;
      while (k < 8 && !act[k]) k++;
      return (k < 8) ? 3'(k) : 3'd0;
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] addr);
      logic [7:0] act;
      act = mIpr & mIer;
      case (addr[11:0])
         12'h000: return {24'h0, mIer};
         12'h004: return {24'h0, mIpr};
         12'h008: return {24'h0, mItr};
         12'h00C: return {(act != 8'h0), 28'h0, modelId(act)};
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit modelWriteOk();
      return psel && penable && pwrite && !addrError(paddr, 1'b1);
   endfunction

   // Each source: fires on a rise (edge mode) or while high (level mode);
   // stays pending unless a clean clear hits it and it did not fire.
   function automatic logic [7:0] nextPending();
      logic [7:0]  p;
      logic [11:0] off;
      off = paddr[11:0];
      for (int i = 0; i < 8; i++) begin
         bit fire;
         bit clr;
         fire = mItr[i] ? (intr_src[i] && !mSrcPrev[i]) : intr_src[i];
         clr  = modelWriteOk() &&
                ((off == 12'h004 && pwdata[i]) ||
                 (off == 12'h010 && int'(pwdata[2:0]) == i));
         p[i] = fire || (mIpr[i] && !clr);
      end
      return p;
   endfunction

   // Behavioural model advanced on every clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mIer     <= '0;
         mIpr     <= '0;
         mItr     <= '0;
         mSrcPrev <= '0;
         mIrq     <= 1'b0;
      end else begin
         mIpr     <= nextPending();
         mIrq     <= (mIpr & mIer) != 8'h0;
         mSrcPrev <= intr_src;
         if (modelWriteOk() && paddr[11:0] == 12'h000) mIer <= pwdata[7:0];
         if (modelWriteOk() && paddr[11:0] == 12'h008) mItr <= pwdata[7:0];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Monitor: compares each access-phase response against the queued expectation.
   always @(negedge clk) begin
      checkOutput("pready", 32'(pready), 32'(psel && penable));
      if (psel && penable) begin
         if (expQ.size() == 0) begin
            checkCount++;
            errCount++;
            $display("[TB] FAIL scoreboard: got access with no expectation at %0t", $time);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("prdata", prdata, monExp.data);
            checkOutput("pslverr", 32'(pslverr), 32'(monExp.err));
         end
      end else begin
         checkOutput("idle_prdata", prdata, 32'h0);
         checkOutput("idle_pslverr", 32'(pslverr), 32'h0);
      end
      checkOutput("irq", 32'(irq), 32'(mIrq));
      checkOutput("irq_id", 32'(irq_id), 32'(modelId(mIpr & mIer)));
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (randSrc && $urandom_range(0, 2) == 0) intr_src = 8'($urandom());
   endtask

   // One full APB transfer; the expected response is queued for the monitor.
   task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                                input logic [31:0] data,
                                output logic [31:0] rdata, output logic err);
      respT e;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      tick();
      penable = 1'b1;
      e.err   = addrError(addr, wr);
      e.data  = (wr || e.err) ? 32'h0 : modelRead(addr);
      expQ.push_back(e);
      @(negedge clk);
      rdata = prdata;
      err   = pslverr;
      tick();
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] r;
      logic        e;
      applyStimulus(1'b1, addr, data, r, e);
   endtask

   task automatic readReg(input logic [31:0] addr, input logic [31:0] expected,
                          input string name);
      logic [31:0] r;
      logic        e;
      applyStimulus(1'b0, addr, 32'h0, r, e);
      checkOutput(name, r, expected);
      checkOutput({name, "_err"}, 32'(e), 32'h0);
   endtask

   task automatic errAccess(input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input string name);
      logic [31:0] r;
      logic        e;
      applyStimulus(wr, addr, data, r, e);
      checkOutput({name, "_err"}, 32'(e), 32'h1);
      checkOutput({name, "_data"}, r, 32'h0);
   endtask

   task automatic pulseSrc(input logic [7:0] mask);
      intr_src = mask;
      tick();
      intr_src = 8'h0;
      tick();
   endtask

   // Write whose access phase is cut short by reset.
   task automatic midTransferReset(input logic [31:0] addr, input logic [31:0] data);
      respT e;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = addr;
      pwdata  = data;
      tick();
      penable = 1'b1;
      e.err   = addrError(addr, 1'b1);
      e.data  = 32'h0;
      expQ.push_back(e);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      tick();
      psel    = 1'b0;
      penable = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [31:0] addr;
      logic [31:0] rdata;
      logic [11:0] off;
      logic        err;

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      readReg(32'h000, 32'h0, "rst_ier");
      readReg(32'h004, 32'h0, "rst_ipr");
      readReg(32'h008, 32'h0, "rst_itr");
      readReg(32'h00C, 32'h0, "rst_id");
      checkOutput("rst_irq", 32'(irq), 32'h0);

      writeReg(32'h000, 32'h01);
      writeReg(32'h008, 32'h01);
      pulseSrc(8'h01);
      checkOutput("edge_irq", 32'(irq), 32'h1);
      readReg(32'h004, 32'h01, "edge_ipr");
      readReg(32'h00C, 32'h8000_0000, "edge_id");
      writeReg(32'h010, 32'h0);
      tick();
      checkOutput("ack_irq", 32'(irq), 32'h0);

      writeReg(32'h000, 32'hFF);
      writeReg(32'h008, 32'hFF);
      pulseSrc(8'h24);
      readReg(32'h00C, 32'h8000_0002, "prio_id2");
      writeReg(32'h004, 32'h04);
      readReg(32'h00C, 32'h8000_0005, "prio_id5");
      writeReg(32'h004, 32'hFF);
      readReg(32'h004, 32'h00, "prio_clear");

      writeReg(32'h008, 32'h00);
      intr_src = 8'h08;
      tick();
      writeReg(32'h004, 32'h08);
      readReg(32'h004, 32'h08, "level_setwins");
      intr_src = 8'h00;
      tick();
      writeReg(32'h004, 32'h08);
      readReg(32'h004, 32'h00, "level_clear");

      writeReg(32'h008, 32'hFF);
      writeReg(32'h000, 32'h00);
      pulseSrc(8'h80);
      readReg(32'h004, 32'h80, "mask_ipr");
      checkOutput("mask_irq_off", 32'(irq), 32'h0);
      writeReg(32'h000, 32'h80);
      tick();
      checkOutput("mask_irq_on", 32'(irq), 32'h1);

      errAccess(1'b0, 32'h014, 32'h0, "rd_0x14");
      errAccess(1'b1, 32'h014, 32'hFF, "wr_0x14");
      errAccess(1'b0, 32'h002, 32'h0, "rd_0x02");
      errAccess(1'b1, 32'h002, 32'h0, "wr_0x02");
      errAccess(1'b1, 32'h001, 32'h0, "wr_0x01");
      errAccess(1'b1, 32'h00C, 32'hFF, "wr_id");
      errAccess(1'b0, 32'h010, 32'h0, "rd_ack");
      readReg(32'h000, 32'h80, "err_ier");
      readReg(32'h004, 32'h80, "err_ipr");
      readReg(32'h008, 32'hFF, "err_itr");
      readReg(32'hABCD_E000, 32'h80, "alias_ier");

      writeReg(32'h008, 32'h00);
      readReg(32'h004, 32'h80, "itr_keeps_ipr");
      writeReg(32'h010, 32'h7);
      readReg(32'h004, 32'h00, "ack7");

      midTransferReset(32'h000, 32'h5A);
      readReg(32'h000, 32'h00, "abort_ier");
      readReg(32'h008, 32'h00, "abort_itr");

      randSrc = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (i % 150 == 75) begin
            midTransferReset({20'($urandom()), 12'h008}, $urandom());
         end else if ($urandom_range(0, 9) < 3) begin
            tick();
         end else begin
            case ($urandom_range(0, 7))
               0:       off = 12'h000;
               1:       off = 12'h004;
               2:       off = 12'h008;
               3:       off = 12'h00C;
               4:       off = 12'h010;
               5:       off = 12'h014;
               6:       off = 12'($urandom_range(0, 15));
               default: off = 12'($urandom());
            endcase
            addr = {20'($urandom()), off};
            applyStimulus(1'($urandom_range(0, 1)), addr, $urandom(), rdata, err);
         end
      end
      randSrc  = 1'b0;
      intr_src = 8'h0;
      repeat (3) tick();
      for (int r = 0; r < 4; r++) begin
         applyStimulus(1'b0, 32'(r * 4), 32'h0, rdata, err);
      end

      checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8, number of interrupt sources; the block SHALL support only the value 8.
REQ-002 clk  input  1  clock; all state SHALL be updated on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 psel  input  1  APB slave select.
REQ-005 penable  input  1  APB access phase.
REQ-006 pwrite  input  1  APB direction; 1 = write.
REQ-007 paddr  input  32  APB byte address; only paddr[11:0] SHALL be decoded.
REQ-008 pwdata  input  32  APB write data.
REQ-009 prdata  output  32  APB read data.
REQ-010 pready  output  1  APB ready.
REQ-011 pslverr  output  1  APB error.
REQ-012 intr_src  input  NUM_SRC  interrupt requests, synchronous to clk; bit 0 is driven by the timer wrapper's intr_timer.
REQ-013 irq  output  1  combined interrupt to the CPU.
REQ-014 irq_id  output  3  index of the highest-priority active source.

Function
REQ-015 Registers, word offsets: 0x00 IER (enable, RW), 0x04 IPR (pending, read / write-1-to-clear), 0x08 ITR (trigger mode, RW; 0 = level, 1 = rising edge), 0x0C ID (RO: bit31 = valid, bits[2:0] = id), 0x10 ACK (WO: pwdata[2:0] clears that pending bit).
REQ-016 Only bits [7:0] of IER, IPR and ITR SHALL be implemented; other bits SHALL read 0 and ignore writes.
REQ-017 APB timing: zero wait states; pready SHALL equal psel & penable.
REQ-018 Register state SHALL change only on the clock edge where psel & penable & pready are all 1.
REQ-019 prdata SHALL be valid combinationally during the access phase and SHALL be 0 outside reads.
REQ-020 pslverr SHALL be 1 in the access phase for:
- an unmapped offset;
- paddr[1:0] != 0;
- a write to ID;
- a read of ACK.
REQ-021 An erroring access SHALL change no state and SHALL return prdata = 0.
REQ-022 Edge mode: the block SHALL keep a previous-sample register src_q of intr_src; pending[i] SHALL set on the cycle after intr_src[i] & ~src_q[i].
REQ-023 Level mode: pending[i] SHALL be set every cycle in which intr_src[i] = 1.
REQ-024 Clearing: pending[i] SHALL clear on an IPR write with pwdata[i] = 1, or on an ACK write with pwdata[2:0] = i.
REQ-025 Set and clear of the same pending bit in the same cycle: set SHALL win.
REQ-026 Consequence of REQ-023/025: a level source held high cannot be cleared.
REQ-027 Pending bits SHALL set regardless of IER; enable SHALL only gate reporting.
REQ-028 active = IPR & IER. Priority is fixed: lowest index wins.
REQ-029 irq_id SHALL be the index of the lowest set bit of active, or 0 when active = 0.
REQ-030 ID register SHALL read {active != 0, 28'b0, irq_id}; reading it SHALL have no side effects.
REQ-031 irq SHALL be registered: irq <= |active, giving 1 cycle latency from a pending/enable change to irq.
REQ-032 irq_id SHALL be combinational from the current active state.
REQ-033 A change of ITR SHALL take effect on the next cycle; the current pending value SHALL be kept.

Reset
REQ-034 On rst_n low, asynchronously: IER, IPR, ITR, src_q and irq SHALL be 0.
REQ-035 In reset, prdata, pready and pslverr SHALL follow REQ-017/019 and therefore be 0 while psel = 0.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer with no partial register update.
REQ-037 After reset deasserts, a source already high in edge mode SHALL set pending on the first clock, because src_q = 0.

Structure
REQ-038 Package irq_ctrl_pkg SHALL hold NUM_SRC, the register offset localparams and the ID valid-bit position.
REQ-039 Sub-module irq_prio_enc (8-bit active in -> 3-bit id + valid out, combinational) SHALL perform the priority encoding.
REQ-040 Everything else SHALL be a single flat module.

Verification
REQ-041 Reset: read all registers -> 0x0; irq = 0.
REQ-042 Edge timer interrupt:
- stimulus: write IER = 0x01, ITR = 0x01; pulse intr_src[0] for 1 cycle;
- required: IPR = 0x01 next cycle; irq = 1 one cycle later; ID reads 0x80000000;
- then write ACK = 0 -> irq = 0 one cycle later.
REQ-043 Priority: IER = 0xFF, edge mode, pulse sources 5 and 2 together -> ID = 0x80000002; write IPR = 0x04 -> ID = 0x80000005.
REQ-044 Level set-wins: ITR = 0, intr_src[3] held high, write IPR = 0x08 -> IPR stays 0x08; drop the source, write IPR = 0x08 -> IPR = 0x00.
REQ-045 Masking: IER = 0x00, pulse source 7 -> IPR = 0x80 and irq = 0; then write IER = 0x80 -> irq = 1 one cycle later.
REQ-046 Errors: access offset 0x14, offset 0x02 and a write to ID -> each gives pslverr = 1, prdata = 0 and no register change.
